// File: rtl/output_datapath.sv
// Drain side of the systolic MAC array: captures the 4x4 accumulator matrix and streams it as 4 beats.
// Define OUT_TRANSPOSE_EN to stream columns instead of rows.
module output_datapath #(
    parameter int unsigned ACC_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mac_done,
    input  logic [16*ACC_W-1:0] c_in,
    input  logic                dest_ready,
    output logic [4*ACC_W-1:0]  data_out,
    output logic                src_valid,
    output logic                tx_done,
    output logic                busy,
    output logic                overrun
);

    localparam int unsigned BEAT_W = 4 * ACC_W;
    localparam int unsigned MAT_W  = 16 * ACC_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [1:0]         idx;
    logic [MAT_W-1:0]   mat;

    // Beat k of matrix m; element 0 of the beat lands in the MSBs.
    function automatic logic [BEAT_W-1:0] pack_beat(input logic [MAT_W-1:0] m, input logic [1:0] k);
        logic [BEAT_W-1:0] b;
        b = '0;
        for (int unsigned j = 0; j < 4; j++) begin
`ifdef OUT_TRANSPOSE_EN
            b[(3-j)*ACC_W +: ACC_W] = m[(4*j + 32'(k))*ACC_W +: ACC_W];
`else
            b[(3-j)*ACC_W +: ACC_W] = m[(4*32'(k) + j)*ACC_W +: ACC_W];
`endif
        end
        return b;
    endfunction

    // Handshake status decodes straight from the state register, so dest_ready never reaches src_valid.
    assign src_valid = (state == SEND);
    assign tx_done   = (state == DONE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= 2'd0;
            mat      <= '0;
            data_out <= '0;
            overrun  <= 1'b0;
        end else begin
            if (mac_done && (state != IDLE)) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (mac_done) begin
                        mat      <= c_in;
                        idx      <= 2'd0;
                        data_out <= pack_beat(c_in, 2'd0);
                        state    <= SEND;
                    end
                end
                SEND: begin
                    // data_out is preloaded with the next beat so it is valid the cycle after acceptance.
                    if (dest_ready) begin
                        if (idx == 2'd3) begin
                            state <= DONE;
                        end else begin
                            idx      <= idx + 2'd1;
                            data_out <= pack_beat(mat, idx + 2'd1);
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_output_datapath.sv
// Scoreboard bench for output_datapath: a transaction-level model queues expected beats, a monitor checks them.
module tb_output_datapath;

    localparam int unsigned ACC_W = 16;
    localparam int unsigned BW    = 4 * ACC_W;
    localparam int unsigned MW    = 16 * ACC_W;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          mac_done = 1'b0;
    logic [MW-1:0] c_in = '0;
    logic          dest_ready = 1'b0;
    logic [BW-1:0] data_out;
    logic          src_valid, tx_done, busy, overrun;

    output_datapath #(.ACC_W(ACC_W)) dut (
        .clk(clk), .reset(reset), .mac_done(mac_done), .c_in(c_in),
        .dest_ready(dest_ready), .data_out(data_out), .src_valid(src_valid),
        .tx_done(tx_done), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: matrix-level view of the transfer.
    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] cur[4];
    logic [BW-1:0] hold = '0;
    int            remaining = 0;
    bit            done_cyc = 0;
    bit            ovr = 0;
    bit            was_idle;
    bit            mon_en = 0;

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [ACC_W-1:0] elem(input logic [MW-1:0] m, input int r, input int c);
        return m[(4*r + c)*ACC_W +: ACC_W];
    endfunction

    function automatic logic [BW-1:0] model_beat(input logic [MW-1:0] m, input int k);
`ifdef OUT_TRANSPOSE_EN
        return {elem(m, 0, k), elem(m, 1, k), elem(m, 2, k), elem(m, 3, k)};
`else
        return {elem(m, k, 0), elem(m, k, 1), elem(m, k, 2), elem(m, k, 3)};
`endif
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            remaining = 0;
            done_cyc  = 0;
            ovr       = 0;
            hold      = '0;
            exp_q.delete();
        end else begin
            was_idle = (remaining == 0) && !done_cyc;
            done_cyc = 0;
            if (remaining > 0 && dest_ready) begin
                hold = cur[4 - remaining];
                remaining--;
                if (remaining == 0) done_cyc = 1;
            end
            if (mac_done) begin
                if (was_idle) begin
                    for (int k = 0; k < 4; k++) begin
                        cur[k] = model_beat(c_in, k);
                        exp_q.push_back(cur[k]);
                    end
                    remaining = 4;
                end else begin
                    ovr = 1;
                end
            end
        end
    end

    // Monitor: flags every cycle, beat payload whenever the DUT presents one.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("src_valid", BW'(src_valid), BW'(remaining > 0));
            chk("busy", BW'(busy), BW'((remaining > 0) || done_cyc));
            chk("tx_done", BW'(tx_done), BW'(done_cyc));
            chk("overrun", BW'(overrun), BW'(ovr));
            if (src_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", data_out, ~data_out);
                end else begin
                    chk("beat", data_out, exp_q[0]);
                    if (dest_ready) void'(exp_q.pop_front());
                end
            end else begin
                chk("data_hold", data_out, hold);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [MW-1:0] m);
        c_in     = m;
        mac_done = 1'b1;
        tick();
        mac_done = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!((remaining == 0) && !done_cyc) && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) chk("idle_timeout", BW'(busy), BW'(0));
    endtask

    function automatic logic [MW-1:0] ramp_mat(input int offs);
        logic [MW-1:0] m;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                m[(4*r + c)*ACC_W +: ACC_W] = ACC_W'(16*r + c + offs);
        return m;
    endfunction

    function automatic logic [MW-1:0] rand_mat();
        logic [MW-1:0] m;
        for (int i = 0; i < 8; i++) m[i*32 +: 32] = $urandom;
        return m;
    endfunction

    logic [BW-1:0] k0, k3;

    initial begin
`ifdef OUT_TRANSPOSE_EN
        k0 = 64'h0000_0010_0020_0030;
        k3 = 64'h0003_0013_0023_0033;
`else
        k0 = 64'h0000_0001_0002_0003;
        k3 = 64'h0030_0031_0032_0033;
`endif
        tick();
        tick();
        mon_en = 1;
        reset  = 1'b0;
        tick();

        // Ramp matrix with ready held high, plus fixed beat constants.
        dest_ready = 1'b1;
        pulse(ramp_mat(0));
        @(negedge clk);
        chk("ramp_beat0", data_out, k0);
        tick(); tick(); tick();
        @(negedge clk);
        chk("ramp_beat3", data_out, k3);
        tick();
        @(negedge clk);
        chk("ramp_tx_done", BW'(tx_done), BW'(1));

        // Back-to-back: next matrix in the first IDLE cycle.
        wait_idle();
        pulse(ramp_mat(256));
        wait_idle();
        pulse(rand_mat());

        // Backpressure during beat 1.
        wait_idle();
        pulse(ramp_mat(0));
        tick();
        dest_ready = 1'b0;
        tick(); tick(); tick();
        dest_ready = 1'b1;

        // Overrun: second mac_done during SEND with a different matrix.
        wait_idle();
        pulse(ramp_mat(0));
        pulse(ramp_mat(4096));
        wait_idle();

        // Reset after beat 1 accepted, then a fresh stream.
        pulse(ramp_mat(0));
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_data_out", data_out, '0);
        chk("rst_overrun", BW'(overrun), BW'(0));
        tick();
        pulse(ramp_mat(0));
        wait_idle();

        // Randomised traffic: ready, mac_done and matrices all random.
        for (int i = 0; i < 600; i++) begin
            dest_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 7) == 0) begin
                c_in     = rand_mat();
                mac_done = 1'b1;
            end else begin
                mac_done = 1'b0;
            end
            if (i == 300) reset = 1'b1;
            tick();
            reset = 1'b0;
        end
        mac_done   = 1'b0;
        dest_ready = 1'b1;
        wait_idle();
        tick();
        chk("queue_drained", BW'(exp_q.size()), BW'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
